// File: rtl/bram_pattern_scheduler.sv
// Command-driven playback sequencer: replays queued BRAM segments onto a 32-bit AXI stream,
// optionally aligning each play to the orbit marker, with full TREADY backpressure.
module bram_pattern_scheduler #(
  parameter int MEM_DEPTH  = 2048,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_start,
  input  logic [15:0] cmd_length,
  input  logic [7:0]  cmd_repeat,
  input  logic        cmd_wait_orbit,
  input  logic        fc_orbitSync,
  output logic        bram_CLK,
  output logic        bram_EN,
  output logic [31:0] bram_ADDR,
  input  logic [31:0] bram_DOUT,
  output logic [31:0] data_stream_TDATA,
  output logic        data_stream_TVALID,
  input  logic        data_stream_TREADY,
  output logic        busy,
  output logic        segment_done,
  output logic        underrun
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0]   PTR_ONE  = 1;
  localparam logic [AW-1:0] ADDR_ONE = 1;

  typedef struct packed {
    logic [AW-1:0] start;
    logic [15:0]   length;
    logic [7:0]    repeats;
    logic          waitOrbit;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ARM, PLAY, NEXT} state_t;

  cmd_t          fifoMem_q [FIFO_DEPTH];
  logic [FW:0]   wrPtr_q, rdPtr_q;
  logic          fifoEmpty, fifoFull, push, pop;
  cmd_t          head;

  state_t        state_q, state_d;
  logic [AW-1:0] wordAddr_q, wordAddr_d, startAddr_q, startAddr_d, lastAddr_q;
  logic [15:0]   len_q, len_d, remLen_q, remLen_d;
  logic [7:0]    repLeft_q, repLeft_d;
  logic          waitOrbit_q, waitOrbit_d;
  logic          issue, loadCmd, credit;

  logic [31:0]   skidMem_q [2];
  logic          skidWr_q, skidRd_q, inFlight_q, popOut;
  logic [1:0]    skidCnt_q;

  logic          unusedStartHi;
  assign unusedStartHi = ^cmd_start[15:AW];

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[FW] != rdPtr_q[FW]) && (wrPtr_q[FW-1:0] == rdPtr_q[FW-1:0]);
  assign push      = cmd_valid && !fifoFull;
  assign cmd_ready = !fifoFull;
  assign head      = fifoMem_q[rdPtr_q[FW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q[FW-1:0]] <= '{start: cmd_start[AW-1:0], length: cmd_length,
                                      repeats: cmd_repeat, waitOrbit: cmd_wait_orbit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (pop)  rdPtr_q <= rdPtr_q + PTR_ONE;
    end
  end

  // A read may issue only if the word it returns is guaranteed a skid slot, crediting
  // the word leaving the buffer this cycle so back-to-back reads sustain full rate.
  assign data_stream_TVALID = (skidCnt_q != 2'd0);
  assign data_stream_TDATA  = skidMem_q[skidRd_q];
  assign popOut             = data_stream_TVALID && data_stream_TREADY;
  assign credit = ({1'b0, skidCnt_q} + {2'b00, inFlight_q}) < (3'd2 + {2'b00, popOut});

  always_comb begin
    state_d      = state_q;
    wordAddr_d   = wordAddr_q;
    startAddr_d  = startAddr_q;
    len_d        = len_q;
    remLen_d     = remLen_q;
    repLeft_d    = repLeft_q;
    waitOrbit_d  = waitOrbit_q;
    issue        = 1'b0;
    loadCmd      = 1'b0;
    pop          = 1'b0;
    segment_done = 1'b0;
    underrun     = 1'b0;
    case (state_q)
      IDLE: if (!fifoEmpty && enable) loadCmd = 1'b1;
      ARM:  if (enable && (!waitOrbit_q || fc_orbitSync)) state_d = PLAY;
      PLAY: begin
        if (enable && credit) begin
          issue      = 1'b1;
          wordAddr_d = wordAddr_q + ADDR_ONE;
          remLen_d   = remLen_q - 16'd1;
          if (remLen_q == 16'd1) begin
            if (repLeft_q != 8'd0) begin
              repLeft_d  = repLeft_q - 8'd1;
              wordAddr_d = startAddr_q;
              remLen_d   = len_q;
              state_d    = waitOrbit_q ? ARM : PLAY;
            end else begin
              segment_done = 1'b1;
              state_d      = NEXT;
            end
          end
        end
      end
      NEXT: begin
        if (fifoEmpty) begin
          underrun = 1'b1;
          state_d  = IDLE;
        end else if (enable) begin
          loadCmd = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Zero-length commands retire immediately and fall through to the next queued one.
    if (loadCmd) begin
      pop         = 1'b1;
      startAddr_d = head.start;
      wordAddr_d  = head.start;
      len_d       = head.length;
      remLen_d    = head.length;
      repLeft_d   = head.repeats;
      waitOrbit_d = head.waitOrbit;
      if (head.length == 16'd0) begin
        segment_done = 1'b1;
        state_d      = NEXT;
      end else begin
        state_d = ARM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wordAddr_q  <= '0;
      startAddr_q <= '0;
      lastAddr_q  <= '0;
      len_q       <= '0;
      remLen_q    <= '0;
      repLeft_q   <= '0;
      waitOrbit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordAddr_q  <= wordAddr_d;
      startAddr_q <= startAddr_d;
      len_q       <= len_d;
      remLen_q    <= remLen_d;
      repLeft_q   <= repLeft_d;
      waitOrbit_q <= waitOrbit_d;
      if (issue) lastAddr_q <= wordAddr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skidMem_q[0] <= '0;
      skidMem_q[1] <= '0;
      skidWr_q     <= 1'b0;
      skidRd_q     <= 1'b0;
      skidCnt_q    <= '0;
      inFlight_q   <= 1'b0;
    end else begin
      if (inFlight_q) begin
        skidMem_q[skidWr_q] <= bram_DOUT;
        skidWr_q            <= ~skidWr_q;
      end
      if (popOut) skidRd_q <= ~skidRd_q;
      skidCnt_q  <= skidCnt_q + {1'b0, inFlight_q} - {1'b0, popOut};
      inFlight_q <= issue;
    end
  end

  assign bram_CLK  = clk;
  assign bram_EN   = issue;
  assign bram_ADDR = {{(30-AW){1'b0}}, (issue ? wordAddr_q : lastAddr_q), 2'b00};
  assign busy      = (state_q != IDLE) || (skidCnt_q != 2'd0) || inFlight_q;

endmodule

// File: tb/tb_bram_pattern_scheduler.sv
// Scoreboard bench for bram_pattern_scheduler: commands push expected words, a negedge
// monitor compares every presented stream word against the queue head.
module tb_bram_pattern_scheduler;
  localparam int MEM_DEPTH  = 2048;
  localparam int FIFO_DEPTH = 8;
  localparam int AW         = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_start = '0;
  logic [15:0] cmd_length = '0;
  logic [7:0]  cmd_repeat = '0;
  logic        cmd_wait_orbit = 1'b0;
  logic        fc_orbitSync = 1'b0;
  logic        bram_CLK;
  logic        bram_EN;
  logic [31:0] bram_ADDR;
  logic [31:0] bram_DOUT = '0;
  logic [31:0] data_stream_TDATA;
  logic        data_stream_TVALID;
  logic        data_stream_TREADY = 1'b1;
  logic        busy;
  logic        segment_done;
  logic        underrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lastPushCyc = 0;
  int sb[$];
  int wordsSeen = 0;
  int segDoneCnt = 0;
  int underrunCnt = 0;
  int pausedReads = 0;
  int strayWords = 0;
  bit randReady = 1'b0;

  bram_pattern_scheduler #(.MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_length(cmd_length), .cmd_repeat(cmd_repeat), .cmd_wait_orbit(cmd_wait_orbit),
    .fc_orbitSync(fc_orbitSync),
    .bram_CLK(bram_CLK), .bram_EN(bram_EN), .bram_ADDR(bram_ADDR), .bram_DOUT(bram_DOUT),
    .data_stream_TDATA(data_stream_TDATA), .data_stream_TVALID(data_stream_TVALID),
    .data_stream_TREADY(data_stream_TREADY),
    .busy(busy), .segment_done(segment_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pattern memory holds its own word index.
  always @(posedge clk) if (bram_EN) bram_DOUT <= {{(32-AW){1'b0}}, bram_ADDR[AW+1:2]};

  always @(posedge clk) begin
    #1;
    data_stream_TREADY = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Monitor: every presented word must equal the scoreboard head, also while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      if (segment_done) segDoneCnt++;
      if (underrun) underrunCnt++;
      if (bram_EN && !enable) pausedReads++;
      if (data_stream_TVALID) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          strayWords++;
          $display("[TB] FAIL stray word: got %0d with empty scoreboard, required no TVALID", data_stream_TDATA);
        end else begin
          checkOutput("stream word", data_stream_TDATA, sb[0]);
          if (data_stream_TREADY) begin
            void'(sb.pop_front());
            wordsSeen++;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int start, input int len, input int rep, input bit waitOrbit, input int budget);
    int waited = 0;
    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_start      = 16'(start);
    cmd_length     = 16'(len);
    cmd_repeat     = 8'(rep);
    cmd_wait_orbit = waitOrbit;
    while (!cmd_ready && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL command accept timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, waited);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    lastPushCyc = cyc;
    for (int p = 0; p <= rep; p++)
      for (int w = 0; w < len; w++)
        sb.push_back(((start % MEM_DEPTH) + w) % MEM_DEPTH);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy) && n < budget);
    if (sb.size() != 0 || busy) begin
      total++;
      bad++;
      $display("[TB] FAIL %s drain timeout: outstanding=%0d busy=%0b, required 0 and 0", name, sb.size(), busy);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seg0, und0, words0, paused0, stray0, lastOrbit, bursts;
    bit prevValid;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset cmd_ready", cmd_ready, 1);
    checkOutput("reset bram_EN", bram_EN, 0);
    checkOutput("reset bram_ADDR", bram_ADDR, 0);
    checkOutput("reset TVALID", data_stream_TVALID, 0);
    checkOutput("reset TDATA", data_stream_TDATA, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset segment_done", segment_done, 0);
    checkOutput("reset underrun", underrun, 0);

    $display("[TB] basic play with repeat");
    seg0 = segDoneCnt;
    und0 = underrunCnt;
    applyStimulus(10, 4, 1, 1'b0, 20);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_stream_TVALID) break;
    end
    checkOutput("first TVALID latency", cyc - lastPushCyc, 4);
    waitIdle("basic", 200);
    checkOutput("basic segment_done count", segDoneCnt - seg0, 1);
    checkOutput("basic underrun count", underrunCnt - und0, 1);
    checkOutput("basic busy after drain", busy, 0);

    $display("[TB] address wrap");
    applyStimulus(2046, 4, 0, 1'b0, 20);
    waitIdle("wrap", 200);

    $display("[TB] orbit-aligned plays");
    seg0 = segDoneCnt;
    applyStimulus(300, 3, 2, 1'b1, 20);
    lastOrbit = -1000;
    bursts = 0;
    prevValid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      fc_orbitSync = (k % 20 == 5);
      if (fc_orbitSync) lastOrbit = cyc;
      if (data_stream_TVALID && !prevValid) begin
        bursts++;
        checkOutput("orbit to burst latency", cyc - lastOrbit, 3);
      end
      prevValid = data_stream_TVALID;
    end
    fc_orbitSync = 1'b0;
    checkOutput("orbit burst count", bursts, 3);
    waitIdle("orbit", 100);
    checkOutput("orbit segment_done count", segDoneCnt - seg0, 1);

    $display("[TB] random backpressure");
    seg0 = segDoneCnt;
    words0 = wordsSeen;
    randReady = 1'b1;
    applyStimulus(100, 5, 0, 1'b0, 20);
    applyStimulus(200, 0, 0, 1'b0, 20);
    applyStimulus(300, 7, 0, 1'b0, 20);
    waitIdle("backpressure", 500);
    randReady = 1'b0;
    checkOutput("backpressure word count", wordsSeen - words0, 12);
    checkOutput("backpressure segment_done count", segDoneCnt - seg0, 3);

    $display("[TB] fifo fill while paused");
    seg0 = segDoneCnt;
    @(negedge clk);
    enable = 1'b0;
    paused0 = pausedReads;
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(1000 + 16 * i, 2, 0, 1'b0, 5);
    @(negedge clk);
    checkOutput("cmd_ready when full", cmd_ready, 0);
    repeat (10) @(negedge clk);
    checkOutput("reads while paused", pausedReads - paused0, 0);
    checkOutput("TVALID while paused", data_stream_TVALID, 0);
    enable = 1'b1;
    applyStimulus(1000 + 16 * FIFO_DEPTH, 2, 0, 1'b0, 20);
    waitIdle("pause", 500);
    checkOutput("pause segment_done count", segDoneCnt - seg0, FIFO_DEPTH + 1);

    $display("[TB] reset mid-play");
    applyStimulus(500, 50, 0, 1'b0, 20);
    applyStimulus(700, 5, 0, 1'b0, 20);
    repeat (10) @(negedge clk);
    stray0 = strayWords;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("post-reset TVALID", data_stream_TVALID, 0);
    checkOutput("post-reset bram_EN", bram_EN, 0);
    checkOutput("post-reset cmd_ready", cmd_ready, 1);
    checkOutput("post-reset busy", busy, 0);
    repeat (20) @(negedge clk);
    checkOutput("words after reset", strayWords - stray0, 0);
    applyStimulus(40, 3, 0, 1'b0, 20);
    waitIdle("after reset", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
